// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants, scheduler state encoding and the zero-operand test.
package fpu_pkg;
  localparam int FP_W = 32;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} sched_state_t;
  // Denormals count as zero, so they skip the datapath.
  function automatic logic fp_is_zero(input logic [FP_W-1:0] x);
    return x[EXP_MSB:EXP_LSB] == '0;
  endfunction
endpackage

// File: rtl/fpu_rr_pick.sv
// fpu_rr_pick: first asserted request at or after ptr, searching upward with wrap.
module fpu_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             found
);
  int j;
  // Scanning from the farthest offset down leaves the nearest hit as the winner.
  always_comb begin
    found = 1'b0;
    gnt_idx = '0;
    j = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      j = (j >= N_REQ) ? j - N_REQ : j;
      if (req[ID_W'(j)]) begin
        found = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
    gnt_onehot = found ? N_REQ'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/fpu_addsub_sched.sv
// fpu_addsub_sched: round-robin sharing of one A-B datapath among N_REQ requesters,
// with zero-operand bypass and a single tagged response port.
module fpu_addsub_sched
  import fpu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LAT = 1,
  parameter int ID_W = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [FP_W*N_REQ-1:0] req_a,
  input  logic [FP_W*N_REQ-1:0] req_b,
  input  logic [N_REQ-1:0]      req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [FP_W-1:0]       rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy,
  output logic [FP_W-1:0]       dp_a,
  output logic [FP_W-1:0]       dp_b,
  input  logic [FP_W-1:0]       dp_s
);
  sched_state_t state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, rsp_id_q, rsp_id_d, gnt_idx;
  logic [FP_W-1:0] dp_a_q, dp_a_d, dp_b_q, dp_b_d, rsp_data_q, rsp_data_d;
  logic [FP_W-1:0] a_sel, b_sel, b_eff;
  logic [1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_onehot;
  logic found, a_z, b_z;

  fpu_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req(req_valid), .ptr(rr_ptr_q), .gnt_onehot(gnt_onehot), .gnt_idx(gnt_idx), .found(found)
  );

  always_comb begin
    a_sel = req_a[gnt_idx*FP_W +: FP_W];
    b_sel = req_b[gnt_idx*FP_W +: FP_W];
    b_eff = (req_op[gnt_idx] == OP_SUB) ? b_sel : {~b_sel[FP_W-1], b_sel[FP_W-2:0]};
    a_z = fp_is_zero(a_sel);
    b_z = fp_is_zero(b_eff);
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    rsp_id_d = rsp_id_q;
    rsp_data_d = rsp_data_q;
    dp_a_d = dp_a_q;
    dp_b_d = dp_b_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (found) begin
        rsp_id_d = gnt_idx;
        rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        if (a_z || b_z) begin
          rsp_data_d = (a_z && b_z) ? '0 : a_z ? {~b_eff[FP_W-1], b_eff[FP_W-2:0]} : a_sel;
          state_d = RESP;
        end else begin
          dp_a_d = a_sel;
          dp_b_d = b_eff;
          cnt_d = 2'(LAT - 1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = (cnt_q == '0) ? CAPTURE : ISSUE;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 2'd1;
      end
      CAPTURE: begin
        rsp_data_d = dp_s;
        state_d = RESP;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      rsp_id_q <= '0;
      rsp_data_q <= '0;
      dp_a_q <= '0;
      dp_b_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      rsp_id_q <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      dp_a_q <= dp_a_d;
      dp_b_q <= dp_b_d;
      cnt_q <= cnt_d;
    end
  end

  // Grant is suppressed while reset is held, so nothing appears accepted.
  assign req_ready = (rst_n && state_q == IDLE) ? gnt_onehot : '0;
  assign rsp_valid = state_q == RESP;
  assign busy = state_q != IDLE;
  assign rsp_data = rsp_data_q;
  assign rsp_id = rsp_id_q;
  assign dp_a = dp_a_q;
  assign dp_b = dp_b_q;
endmodule

// File: tb/tb_fpu_addsub_sched.sv
// tb_fpu_addsub_sched: directed checks of a LAT=1 and a LAT=3 scheduler with a stub datapath.
module tb_fpu_addsub_sched;
  import fpu_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, rst3_n, rsp_ready;
  logic [3:0] req_valid, req_op;
  logic [3:0][31:0] ra, rb;
  logic [3:0] rdy1, rdy3;
  logic v1, v3, busy1, busy3;
  logic [1:0] id1, id3;
  logic [31:0] data1, data3, dpa1, dpb1, dps1, dpa3, dpb3, dps3;
  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
    if (a == 32'h3F800000 && b == 32'hBF800000) return 32'h40000000;
    return a ^ b;
  endfunction
  assign dps1 = model(dpa1, dpb1);
  assign dps3 = model(dpa3, dpb3);

  fpu_addsub_sched #(.N_REQ(4), .LAT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1), .req_a(ra), .req_b(rb),
    .req_op(req_op), .rsp_valid(v1), .rsp_ready(rsp_ready), .rsp_data(data1), .rsp_id(id1),
    .busy(busy1), .dp_a(dpa1), .dp_b(dpb1), .dp_s(dps1)
  );
  fpu_addsub_sched #(.N_REQ(4), .LAT(3)) u_d3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(req_valid), .req_ready(rdy3), .req_a(ra), .req_b(rb),
    .req_op(req_op), .rsp_valid(v3), .rsp_ready(rsp_ready), .rsp_data(data3), .rsp_id(id3),
    .busy(busy3), .dp_a(dpa3), .dp_b(dpb3), .dp_s(dps3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic send(input int r, input logic op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 4'b1 << r;
    req_op[r] = op;
    ra[r] = a;
    rb[r] = b;
  endtask

  initial begin
    rst_n = 1'b0;
    rst3_n = 1'b0;
    req_valid = '0;
    req_op = '0;
    ra = '0;
    rb = '0;
    rsp_ready = 1'b1;
    nxt();
    nxt();
    chk("rst_ctl", {v1, busy1, rdy1, id1}, 64'd0);
    chk("rst_dp", {dpa1, dpb1}, 64'd0);
    chk("rst_data", data1, 64'd0);
    rst_n = 1'b1;
    nxt();
    // subtract 3.0 - 1.0 on requester 0
    send(0, OP_SUB, 32'h40400000, 32'h3F800000);
    #1 chk("sub_rdy", rdy1, 4'b0001);
    nxt();
    req_valid = '0;
    chk("sub_dp", {dpa1, dpb1}, {32'h40400000, 32'h3F800000});
    chk("sub_c1", {v1, busy1}, 2'b01);
    nxt();
    chk("sub_c2", v1, 1'b0);
    nxt();
    chk("sub_rsp", {v1, id1, data1}, {1'b1, 2'd0, 32'h40000000});
    nxt();
    chk("sub_idle", {v1, busy1}, 2'b00);
    // add 1.0 + 1.0 on requester 2
    send(2, OP_ADD, 32'h3F800000, 32'h3F800000);
    #1 chk("add_rdy", rdy1, 4'b0100);
    nxt();
    req_valid = '0;
    chk("add_dp", {dpa1, dpb1}, {32'h3F800000, 32'hBF800000});
    nxt();
    nxt();
    chk("add_rsp", {v1, id1, data1}, {1'b1, 2'd2, 32'h40000000});
    nxt();
    // fairness from a fresh pointer
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      req_op[r] = OP_SUB;
      ra[r] = 32'h40400000;
      rb[r] = 32'h3F800000;
    end
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1 chk("fair_gnt", rdy1, 4'b1 << (k % 4));
      nxt();
      if (k == 4) req_valid = '0;
      chk("fair_c1", rdy1, 4'b0);
      nxt();
      chk("fair_c2", rdy1, 4'b0);
      nxt();
      chk("fair_rsp", {v1, id1, rdy1}, {1'b1, 2'(k % 4), 4'b0});
      nxt();
    end
    // backpressure on requester 1
    rsp_ready = 1'b0;
    send(1, OP_SUB, 32'h40400000, 32'h3F800000);
    #1 chk("bp_rdy", rdy1, 4'b0010);
    nxt();
    req_valid = '0;
    nxt();
    nxt();
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_hold", {v1, busy1, rdy1, id1, data1}, {1'b1, 1'b1, 4'b0, 2'd1, 32'h40000000});
      nxt();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    nxt();
    chk("bp_done", {v1, busy1}, 2'b00);
    // zero bypass cases on requester 1
    send(1, OP_SUB, 32'h00000000, 32'h40000000);
    #1 chk("byp_rdy", rdy1, 4'b0010);
    nxt();
    req_valid = '0;
    chk("byp_rsp", {v1, id1, data1}, {1'b1, 2'd1, 32'hC0000000});
    chk("byp_dp", {dpa1, dpb1}, {32'h40400000, 32'h3F800000});
    nxt();
    send(1, OP_SUB, 32'h00000000, 32'h00000000);
    nxt();
    req_valid = '0;
    chk("byp_zz", {v1, data1}, {1'b1, 32'h00000000});
    nxt();
    send(1, OP_ADD, 32'h00000000, 32'h40000000);
    nxt();
    req_valid = '0;
    chk("byp_az_add", {v1, data1}, {1'b1, 32'h40000000});
    nxt();
    send(1, OP_ADD, 32'h40400000, 32'h00000000);
    nxt();
    req_valid = '0;
    chk("byp_bz", {v1, data1}, {1'b1, 32'h40400000});
    chk("byp_bz_dp", {dpa1, dpb1}, {32'h40400000, 32'h3F800000});
    nxt();
    // LAT=3 instance: reset while in ISSUE
    rst3_n = 1'b1;
    nxt();
    send(0, OP_SUB, 32'h40400000, 32'h3F800000);
    #1 chk("r3_rdy", rdy3, 4'b0001);
    nxt();
    req_valid = '0;
    chk("r3_issue", {busy3, dpa3}, {1'b1, 32'h40400000});
    nxt();
    req_valid = 4'b1001;
    rst3_n = 1'b0;
    #1 chk("r3_rst_ctl", {v3, busy3, rdy3, id3}, 64'd0);
    chk("r3_rst_dp", {dpa3, dpb3}, 64'd0);
    chk("r3_rst_data", data3, 64'd0);
    nxt();
    req_valid = '0;
    rst3_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 chk("r3_norsp", {v3, busy3}, 2'b00);
      nxt();
    end
    send(3, OP_SUB, 32'h40400000, 32'h3F800000);
    #1 chk("r3_gnt3", rdy3, 4'b1000);
    nxt();
    req_valid = '0;
    nxt();
    nxt();
    nxt();
    chk("r3_c4", v3, 1'b0);
    nxt();
    chk("r3_rsp", {v3, id3, data3}, {1'b1, 2'd3, 32'h40000000});
    nxt();
    req_valid = 4'hF;
    #1 chk("r3_wrap", rdy3, 4'b0001);
    nxt();
    req_valid = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
